// File: rtl/mag_sqrt_sched.sv
// mag_sqrt_sched
//   Round-robin scheduler and sequencer for one shared iterative magnitude
//   engine. Grants one of NREQ requesters, captures its (x, y) operands,
//   squares and sums them, then extracts floor(sqrt(x*x + y*y)) with a
//   bit-serial restoring square root (one result bit per cycle). The result
//   is held until the consumer accepts it.
//
//   Optional build macro: MAG_ROUND_EN
//     defined   -> result rounded to nearest (root+1 when rem > root)
//     undefined -> result is the floor root
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]       per-requester request valid
//   req_x      in   [NREQ*DW]    packed X operands, requester i at [i*DW +: DW]
//   req_y      in   [NREQ*DW]    packed Y operands, same packing
//   req_ready  out  [NREQ]       one-hot grant, only in IDLE
//   res_valid  out               result valid
//   res_ready  in                consumer accepts result
//   res_mag    out  [DW+1]       magnitude result
//   res_id     out  [2]          requester that owns res_mag
//   busy       out               high in any state other than IDLE
module mag_sqrt_sched #(
    parameter int NREQ = 2,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_x,
    input  logic [NREQ*DW-1:0]   req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DW:0]          res_mag,
    output logic [1:0]           res_id,
    output logic                 busy
);

    localparam int unsigned NR = NREQ;
    localparam int          SW = 2 * DW + 2;            // square sum padded to an even width
    localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        SQ,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]   x_q, x_d;
    logic [DW-1:0]   y_q, y_d;
    logic [1:0]      id_q, id_d;
    logic [SW-1:0]   s_q, s_d;
    logic [DW:0]     root_q, root_d;
    logic [DW+1:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            res_valid_q, res_valid_d;
    logic [DW:0]     res_mag_q, res_mag_d;

    logic [NREQ-1:0] grant;
    logic [1:0]      win_idx;
    logic            found;
    logic [SW-1:0]   sq_sum;
    logic [DW+3:0]   shifted;
    logic [DW+4:0]   trial;
    logic [1:0]      unused_trial_bits;
    logic [DW:0]     mag_final;

    // Round-robin search: first pass covers rr_ptr..NREQ-1, second pass wraps
    // to 0..rr_ptr-1. Grant is suppressed while reset is asserted.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        if (state_q == IDLE && rst_n) begin
            for (int unsigned k = 0; k < NR; k++) begin
                if (!found && k >= 32'(rr_ptr_q) && req_valid[k]) begin
                    found    = 1'b1;
                    grant[k] = 1'b1;
                    win_idx  = 2'(k);
                end
            end
            for (int unsigned k = 0; k < NR; k++) begin
                if (!found && k < 32'(rr_ptr_q) && req_valid[k]) begin
                    found    = 1'b1;
                    grant[k] = 1'b1;
                    win_idx  = 2'(k);
                end
            end
        end
    end

    // Datapath helpers for the square and one restoring-sqrt step.
    always_comb begin
        sq_sum  = SW'(x_q) * SW'(x_q) + SW'(y_q) * SW'(y_q);
        shifted = {rem_q, s_q[SW-1 -: 2]};
        trial   = {1'b0, shifted} - {2'b00, root_q, 2'b01};
        // rem never exceeds 2*root, so a non-negative trial fits rem's width.
        unused_trial_bits = trial[DW+3:DW+2];
`ifdef MAG_ROUND_EN
        mag_final = ({1'b0, root_q} < rem_q) ? root_q + (DW+1)'(1) : root_q;
`else
        mag_final = root_q;
`endif
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        x_d         = x_q;
        y_d         = y_q;
        id_d        = id_q;
        s_d         = s_q;
        root_d      = root_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_mag_d   = res_mag_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    x_d     = req_x[int'(win_idx) * DW +: DW];
                    y_d     = req_y[int'(win_idx) * DW +: DW];
                    id_d    = win_idx;
                    rr_ptr_d = (win_idx == 2'(NR - 1)) ? '0 : PW'(win_idx + 2'd1);
                    state_d = SQ;
                end
            end
            SQ: begin
                s_d     = sq_sum;
                root_d  = '0;
                rem_d   = '0;
                cnt_d   = CW'(DW);
                state_d = CALC;
            end
            CALC: begin
                s_d = {s_q[SW-3:0], 2'b00};
                if (!trial[DW+4]) begin
                    rem_d  = trial[DW+1:0];
                    root_d = {root_q[DW-1:0], 1'b1};
                end else begin
                    rem_d  = shifted[DW+1:0];
                    root_d = {root_q[DW-1:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                // First DONE cycle registers the final (optionally rounded)
                // result; res_valid rises together with it.
                if (!res_valid_q) begin
                    res_mag_d   = mag_final;
                    res_valid_d = 1'b1;
                end else if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            id_q        <= '0;
            s_q         <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_mag_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            id_q        <= id_d;
            s_q         <= s_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_mag_q   <= res_mag_d;
        end
    end

    assign req_ready = grant;
    assign res_valid = res_valid_q;
    assign res_mag   = res_mag_q;
    assign res_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mag_sqrt_sched.sv
// Testbench for mag_sqrt_sched (NREQ=2, DW=8). Expected magnitudes come from
// an integer square-root model; build with MAG_ROUND_EN to check rounding.
module tb_mag_sqrt_sched;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int LAT  = DW + 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_x;
    logic [NREQ*DW-1:0]  req_y;
    logic [NREQ-1:0]     req_ready;
    logic                res_valid;
    logic                res_ready;
    logic [DW:0]         res_mag;
    logic [1:0]          res_id;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    mag_sqrt_sched #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_mag   (res_mag),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    function automatic int model_mag(input int x, input int y);
        int s;
        int r;
        s = x * x + y * y;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
`ifdef MAG_ROUND_EN
        if (s - r * r > r) r++;
`endif
        return r;
    endfunction

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    // Raises one request, waits (bounded) for its grant, lets it transfer and
    // waits for the result. Leaves res_valid high for the caller to inspect.
    task automatic do_job(input int id, input int x, input int y,
                          output logic [NREQ-1:0] gnt, output int lat);
        int w;
        req_x = '0;
        req_y = '0;
        req_x[id*DW +: DW] = x[DW-1:0];
        req_y[id*DW +: DW] = y[DW-1:0];
        req_valid = '0;
        req_valid[id] = 1'b1;
        #1;
        w = 0;
        while (req_ready == '0 && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        gnt = req_ready;
        @(posedge clk);
        #1 req_valid = '0;
        wait_result(lat);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({req_ready, res_valid, res_mag, res_id, busy} !== '0) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b v=%b mag=%0d id=%0d busy=%b, want all 0",
                     req_ready, res_valid, res_mag, res_id, busy);
        end
    endtask

    task automatic test_basic();
        logic [NREQ-1:0] gnt;
        int lat;
        do_job(0, 3, 4, gnt, lat);
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL basic_grant: got %b want 01", gnt); end
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        checks++;
        if (res_mag !== 9'(model_mag(3, 4))) begin
            failures++; $display("FAIL basic_mag: got %0d want %0d", res_mag, model_mag(3, 4));
        end
        checks++;
        if (res_id !== 2'd0) begin failures++; $display("FAIL basic_id: got %0d want 0", res_id); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done: got %b want 1", busy); end
        handshake();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++; $display("FAIL basic_after_hs: got busy=%b v=%b want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_boundary();
        logic [NREQ-1:0] gnt;
        int lat;
        do_job(1, 255, 255, gnt, lat);
        checks++;
        if (res_mag !== 9'(model_mag(255, 255)) || res_id !== 2'd1 || lat != LAT) begin
            failures++;
            $display("FAIL max_operands: got mag=%0d id=%0d lat=%0d want mag=%0d id=1 lat=%0d",
                     res_mag, res_id, lat, model_mag(255, 255), LAT);
        end
        handshake();
        do_job(0, 0, 0, gnt, lat);
        checks++;
        if (res_mag !== 9'd0 || res_id !== 2'd0 || lat != LAT) begin
            failures++;
            $display("FAIL zero_operands: got mag=%0d id=%0d lat=%0d want mag=0 id=0 lat=%0d",
                     res_mag, res_id, lat, LAT);
        end
        handshake();
    endtask

    task automatic test_fairness();
        int xs[NREQ];
        int ys[NREQ];
        int w;
        int lat;
        int exp_id;
        int exp_mag;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            xs[i] = $urandom_range(0, 255);
            ys[i] = $urandom_range(0, 255);
            req_x[i*DW +: DW] = xs[i][DW-1:0];
            req_y[i*DW +: DW] = ys[i][DW-1:0];
        end
        req_valid = '1;
        for (int j = 0; j < 6; j++) begin
            exp_id = j % NREQ;
            #1;
            w = 0;
            while (req_ready == '0 && w < 40) begin
                @(posedge clk);
                #1;
                w++;
            end
            checks++;
            if (req_ready !== NREQ'(1 << exp_id)) begin
                failures++;
                $display("FAIL rr_order job%0d: got grant %b want %b", j, req_ready, NREQ'(1 << exp_id));
            end
            exp_mag = model_mag(xs[exp_id], ys[exp_id]);
            @(posedge clk);
            #1;
            xs[exp_id] = $urandom_range(0, 255);
            ys[exp_id] = $urandom_range(0, 255);
            req_x[exp_id*DW +: DW] = xs[exp_id][DW-1:0];
            req_y[exp_id*DW +: DW] = ys[exp_id][DW-1:0];
            wait_result(lat);
            checks++;
            if (res_id !== 2'(exp_id) || res_mag !== 9'(exp_mag)) begin
                failures++;
                $display("FAIL rr_result job%0d: got id=%0d mag=%0d want id=%0d mag=%0d",
                         j, res_id, res_mag, exp_id, exp_mag);
            end
            handshake();
        end
        req_valid = '0;
    endtask

    task automatic test_hold();
        logic [NREQ-1:0] gnt;
        int lat;
        int x;
        int y;
        int exp_mag;
        x = $urandom_range(0, 255);
        y = $urandom_range(0, 255);
        exp_mag = model_mag(x, y);
        do_job(0, x, y, gnt, lat);
        req_x = {8'd6, 8'd0};
        req_y = {8'd8, 8'd0};
        req_valid = '1;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if (res_valid !== 1'b1 || res_mag !== 9'(exp_mag) || res_id !== 2'd0 || req_ready !== '0) begin
                failures++;
                $display("FAIL hold_stable cyc%0d: got v=%b mag=%0d id=%0d rdy=%b want v=1 mag=%0d id=0 rdy=00",
                         c, res_valid, res_mag, res_id, req_ready, exp_mag);
            end
            @(posedge clk);
            #1;
        end
        handshake();
        checks++;
        if (req_ready !== 2'b10) begin
            failures++; $display("FAIL hold_release_grant: got %b want 10", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_result(lat);
        checks++;
        if (res_id !== 2'd1 || res_mag !== 9'(model_mag(6, 8)) || lat != LAT) begin
            failures++;
            $display("FAIL hold_next_job: got id=%0d mag=%0d lat=%0d want id=1 mag=%0d lat=%0d",
                     res_id, res_mag, lat, model_mag(6, 8), LAT);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] gnt;
        int lat;
        int w;
        req_x = {8'd0, 8'd200};
        req_y = {8'd0, 8'd150};
        req_valid = 2'b01;
        #1;
        w = 0;
        while (req_ready == '0 && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        @(posedge clk);
        #1 req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, busy, req_ready, res_mag, res_id} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: got v=%b busy=%b rdy=%b mag=%0d id=%0d want all 0",
                     res_valid, busy, req_ready, res_mag, res_id);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_job(1, 6, 8, gnt, lat);
        checks++;
        if (gnt !== 2'b10 || res_id !== 2'd1 || res_mag !== 9'd10 || lat != LAT) begin
            failures++;
            $display("FAIL midrst_recover: got gnt=%b id=%0d mag=%0d lat=%0d want gnt=10 id=1 mag=10 lat=%0d",
                     gnt, res_id, res_mag, lat, LAT);
        end
        handshake();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] gnt;
        int lat;
        int id;
        int x;
        int y;
        int exp_mag;
        int hold;
        for (int n = 0; n < 1000; n++) begin
            id = $urandom_range(0, NREQ - 1);
            x  = $urandom_range(0, 255);
            y  = $urandom_range(0, 255);
            exp_mag = model_mag(x, y);
            res_ready = 1'($urandom_range(0, 1));
            do_job(id, x, y, gnt, lat);
            checks++;
            if (gnt !== NREQ'(1 << id) || lat != LAT || res_mag !== 9'(exp_mag) || res_id !== 2'(id)) begin
                failures++;
                $display("FAIL random%0d (%0d,%0d): got gnt=%b lat=%0d mag=%0d id=%0d want gnt=%b lat=%0d mag=%0d id=%0d",
                         n, x, y, gnt, lat, res_mag, res_id, NREQ'(1 << id), LAT, exp_mag, id);
            end
            res_ready = 1'b0;
            hold = $urandom_range(0, 3);
            repeat (hold) @(posedge clk);
            #1;
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_fairness();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
